// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared constants and channel state type for tick_scheduler (TICK_SCHED_PERIODIC_EN)
package tick_sched_pkg;

  localparam int CH_NUM           = 4;
  localparam int CH_W             = 2;
  localparam int TICK_DIV_DEFAULT = 100000;

`ifdef TICK_SCHED_PERIODIC_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RELOAD = 2'd2
  } ch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } ch_state_e;
`endif

endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - load/cancel request handshake bundle for tick_scheduler
interface tick_scheduler_if
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [CH_W-1:0]  req_ch;
  logic             req_cancel;
  logic [CNT_W-1:0] req_count;
  logic             req_periodic;

  modport master (
    output req_valid, req_ch, req_cancel, req_count, req_periodic,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_ch, req_cancel, req_count, req_periodic,
    output req_ready
  );

endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a one-cycle timebase tick
module tick_gen
  import tick_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk_100mhz,
  input  logic rst,
  output logic tick
);

  localparam int            PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;

  // wrap to 0 after the last prescaler value
  always_comb begin
    ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
  end

  // prescaler register
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  // tick is forced low while reset is held
  assign tick = !rst && (ps_q == PS_LAST);

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - four-channel tick-count scheduler; periodic reload under TICK_SCHED_PERIODIC_EN
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  tick_scheduler_if.slave   req,
  output logic              tick,
  output logic [CH_NUM-1:0] active,
  output logic [CH_NUM-1:0] expire
);

  ch_state_e         state_q [CH_NUM];
  logic [CNT_W-1:0]  cnt_q   [CH_NUM];
  logic [CH_NUM-1:0] active_q;
  logic [CH_NUM-1:0] expire_q;
`ifdef TICK_SCHED_PERIODIC_EN
  logic [CH_NUM-1:0] periodic_q;
  logic [CNT_W-1:0]  reload_q [CH_NUM];
`else
  logic              unused_periodic;
  assign unused_periodic = req.req_periodic;
`endif

  logic             xfer;
  logic [CNT_W-1:0] load_cnt;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .tick       (tick)
  );

  // requests are refused in the tick cycle so a load never races a decrement
  assign req.req_ready = !rst && !tick;
  assign xfer          = req.req_valid && req.req_ready;
  assign load_cnt      = (req.req_count == '0) ? CNT_W'(1) : req.req_count;

  assign active = active_q & {CH_NUM{!rst}};
  assign expire = expire_q & {CH_NUM{!rst}};

  // per-channel FSM: a request for the channel overrides any tick/reload activity
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      active_q <= '0;
      expire_q <= '0;
`ifdef TICK_SCHED_PERIODIC_EN
      periodic_q <= '0;
`endif
      for (int ch = 0; ch < CH_NUM; ch++) begin
        state_q[ch] <= ST_IDLE;
        cnt_q[ch]   <= '0;
`ifdef TICK_SCHED_PERIODIC_EN
        reload_q[ch] <= '0;
`endif
      end
    end else begin
      expire_q <= '0;
      for (int ch = 0; ch < CH_NUM; ch++) begin
        if (xfer && (req.req_ch == CH_W'(ch))) begin
          if (req.req_cancel) begin
            state_q[ch]  <= ST_IDLE;
            active_q[ch] <= 1'b0;
          end else begin
            state_q[ch]  <= ST_RUN;
            active_q[ch] <= 1'b1;
            cnt_q[ch]    <= load_cnt;
`ifdef TICK_SCHED_PERIODIC_EN
            periodic_q[ch] <= req.req_periodic;
            reload_q[ch]   <= load_cnt;
`endif
          end
        end else begin
          case (state_q[ch])
            ST_RUN: begin
              if (tick) begin
                if (cnt_q[ch] <= CNT_W'(1)) begin
                  cnt_q[ch]    <= '0;
                  expire_q[ch] <= 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
                  if (periodic_q[ch]) begin
                    state_q[ch] <= ST_RELOAD;
                  end else begin
                    state_q[ch]  <= ST_IDLE;
                    active_q[ch] <= 1'b0;
                  end
`else
                  state_q[ch]  <= ST_IDLE;
                  active_q[ch] <= 1'b0;
`endif
                end else begin
                  cnt_q[ch] <= cnt_q[ch] - 1'b1;
                end
              end
            end
`ifdef TICK_SCHED_PERIODIC_EN
            ST_RELOAD: begin
              cnt_q[ch]   <= reload_q[ch];
              state_q[ch] <= ST_RUN;
            end
`endif
            ST_IDLE: begin
              state_q[ch] <= ST_IDLE;
            end
            default: begin
              state_q[ch]  <= ST_IDLE;
              active_q[ch] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - randomized and directed bench for tick_scheduler against a deadline model (TICK_SCHED_PERIODIC_EN aware)
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  localparam int D  = 10;
  localparam int CW = 16;

  logic       clk_100mhz = 1'b0;
  logic       rst        = 1'b1;
  logic       tick;
  logic [3:0] active;
  logic [3:0] expire;

  tick_scheduler_if #(.CNT_W(CW)) req_if ();

  tick_scheduler #(
    .TICK_DIV (D),
    .CNT_W    (CW)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .req        (req_if),
    .tick       (tick),
    .active     (active),
    .expire     (expire)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int vectors     = 0;
  int miscompares = 0;

  // reference model: absolute tick deadlines rather than countdowns
  int       m_cyc;
  int       m_ticks;
  bit       m_on  [4];
  int       m_dl  [4];
  bit       m_per [4];
  int       m_rel [4];
  bit [3:0] m_exp;

  int obs_ticks;
  int obs_exp  [4];
  int obs_last [4];
  bit last_xfer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (model cycle %0d)", tag, got, want, m_cyc);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_ticks = 0;
    m_exp   = '0;
    for (int i = 0; i < 4; i++) begin
      m_on[i]  = 1'b0;
      m_dl[i]  = 0;
      m_per[i] = 1'b0;
      m_rel[i] = 0;
    end
  endtask

  task automatic clear_obs();
    obs_ticks = 0;
    for (int i = 0; i < 4; i++) begin
      obs_exp[i]  = 0;
      obs_last[i] = -1;
    end
  endtask

  // compare one cycle at the falling edge, then advance the model across the rising edge
  task automatic step();
    bit       tk;
    bit       rdy;
    bit [3:0] act;
    bit [3:0] want_exp;
    bit [3:0] nexp;
    int       ch;
    int       cnt;
    @(negedge clk_100mhz);
    tk  = !rst && ((m_cyc % D) == D - 1);
    rdy = !rst && !tk;
    for (int i = 0; i < 4; i++) act[i] = !rst && m_on[i];
    want_exp = rst ? 4'b0 : m_exp;
    check("tick",      32'(tick),             32'(tk));
    check("req_ready", 32'(req_if.req_ready), 32'(rdy));
    check("active",    32'(active),           32'(act));
    check("expire",    32'(expire),           32'(want_exp));
    if (tick === 1'b1) obs_ticks++;
    for (int i = 0; i < 4; i++) begin
      if (expire[i] === 1'b1) begin
        obs_exp[i]++;
        obs_last[i] = m_cyc;
      end
    end
    last_xfer = req_if.req_valid && rdy;
    if (rst) begin
      model_reset();
    end else begin
      nexp = '0;
      if (tk) begin
        m_ticks++;
        for (int i = 0; i < 4; i++) begin
          if (m_on[i] && m_dl[i] == m_ticks) begin
            nexp[i] = 1'b1;
            if (m_per[i]) m_dl[i] = m_dl[i] + m_rel[i];
            else          m_on[i] = 1'b0;
          end
        end
      end
      if (last_xfer) begin
        ch = int'(req_if.req_ch);
        if (req_if.req_cancel) begin
          m_on[ch] = 1'b0;
        end else begin
          cnt      = (req_if.req_count == '0) ? 1 : int'(req_if.req_count);
          m_on[ch] = 1'b1;
          m_dl[ch] = m_ticks + cnt;
          m_rel[ch] = cnt;
`ifdef TICK_SCHED_PERIODIC_EN
          m_per[ch] = req_if.req_periodic;
`else
          m_per[ch] = 1'b0;
`endif
        end
      end
      m_exp = nexp;
      m_cyc++;
    end
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic send(input int ch, input bit cancel, input int count, input bit periodic, output int n);
    req_if.req_valid    = 1'b1;
    req_if.req_ch       = 2'(ch);
    req_if.req_cancel   = cancel;
    req_if.req_count    = CW'(count);
    req_if.req_periodic = periodic;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_xfer && n < 20);
    req_if.req_valid = 1'b0;
    if (!last_xfer) check("send_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_ticks(input int n);
    int start;
    int k;
    start = obs_ticks;
    k     = 0;
    while (obs_ticks < start + n && k < 15 * n) begin
      step();
      k++;
    end
    check("wait_ticks", 32'(obs_ticks - start), 32'(n));
  endtask

  initial begin
    int n;
    int n2;
    int k;
    req_if.req_valid    = 1'b0;
    req_if.req_ch       = '0;
    req_if.req_cancel   = 1'b0;
    req_if.req_count    = '0;
    req_if.req_periodic = 1'b0;
    model_reset();
    clear_obs();

    // reset for 3 cycles, then idle timebase
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    clear_obs();
    run(30);
    check("s030_ticks", 32'(obs_ticks), 32'(3));
    check("s030_no_expire", 32'(obs_exp[0] + obs_exp[1] + obs_exp[2] + obs_exp[3]), 32'(0));

    // one-shot count 3 on ch0
    clear_obs();
    send(0, 1'b0, 3, 1'b0, n);
    run(40);
    check("s031_exp0_count", 32'(obs_exp[0]), 32'(1));
    check("s031_active0", 32'(active[0]), 32'(0));

    // periodic count 2 on ch1
    clear_obs();
    send(1, 1'b0, 2, 1'b1, n);
    run(105);
`ifdef TICK_SCHED_PERIODIC_EN
    check("s032_exp1_count", 32'(obs_exp[1]), 32'(5));
`else
    check("s032_exp1_count", 32'(obs_exp[1]), 32'(1));
`endif
    send(1, 1'b1, 0, 1'b0, n);
    run(3);
    check("s032_active1_cancelled", 32'(active[1]), 32'(0));

    // cancel ch2 mid-count, then reload with a shorter count
    clear_obs();
    send(2, 1'b0, 5, 1'b0, n);
    wait_ticks(2);
    send(2, 1'b1, 0, 1'b0, n);
    check("s033_active2", 32'(active[2]), 32'(0));
    run(60);
    check("s033_no_exp2", 32'(obs_exp[2]), 32'(0));
    send(2, 1'b0, 5, 1'b0, n);
    wait_ticks(2);
    send(2, 1'b0, 1, 1'b0, n);
    clear_obs();
    wait_ticks(1);
    check("s033_not_yet", 32'(obs_exp[2]), 32'(0));
    step();
    check("s033_reload_exp2", 32'(obs_exp[2]), 32'(1));

    // request held across a tick cycle, then two channels expiring together
    clear_obs();
    k = 0;
    while (((m_cyc % D) != D - 1) && k < 20) begin
      step();
      k++;
    end
    send(0, 1'b0, 4, 1'b0, n);
    check("s034_held_over_tick", 32'(n), 32'(2));
    send(3, 1'b0, 4, 1'b0, n2);
    check("s034_back_to_back", 32'(n2), 32'(1));
    run(50);
    check("s034_exp0_count", 32'(obs_exp[0]), 32'(1));
    check("s034_exp3_count", 32'(obs_exp[3]), 32'(1));
    check("s034_same_cycle", 32'(obs_last[0]), 32'(obs_last[3]));

    // reset one tick before expiry
    clear_obs();
    send(0, 1'b0, 2, 1'b0, n);
    wait_ticks(1);
    run(2);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    check("s035_active", 32'(active), 32'(0));
    check("s035_expire", 32'(expire), 32'(0));
    check("s035_tick",   32'(tick),   32'(0));
    clear_obs();
    run(9);
    check("s035_no_early_tick", 32'(obs_ticks), 32'(0));
    run(1);
    check("s035_first_tick", 32'(obs_ticks), 32'(1));
    run(30);
    check("s035_no_exp0", 32'(obs_exp[0]), 32'(0));

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rst                 = ($urandom_range(0, 199) == 0);
      req_if.req_valid    = ($urandom_range(0, 2) == 0);
      req_if.req_ch       = 2'($urandom_range(0, 3));
      req_if.req_cancel   = ($urandom_range(0, 4) == 0);
      req_if.req_count    = CW'($urandom_range(0, 6));
      req_if.req_periodic = 1'($urandom_range(0, 1));
      step();
    end
    rst              = 1'b0;
    req_if.req_valid = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 100000, clk_100mhz cycles per timebase tick (1 ms at 100 MHz); legal range 2..2^27.
REQ-002 Parameter CNT_W, default 16, width of the per-channel tick count.
REQ-003 clk_100mhz  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  load or cancel request present.
REQ-006 req_ready  output  1  scheduler accepts the request this cycle.
REQ-007 req_ch  input  2  target channel, 0..3.
REQ-008 req_cancel  input  1  1 = cancel channel, 0 = load channel.
REQ-009 req_count  input  CNT_W  ticks until expiry.
REQ-010 req_periodic  input  1  reload req_count after each expiry.
REQ-011 tick  output  1  one-cycle timebase pulse.
REQ-012 active  output  4  per-channel running flag.
REQ-013 expire  output  4  per-channel one-cycle expiry pulse.

Function
REQ-014 Prescaler counts 0..TICK_DIV-1 and wraps; tick is high for exactly the one cycle in which the prescaler equals TICK_DIV-1.
REQ-015 A request transfers on a cycle where req_valid and req_ready are both high; req_ready is high in every cycle except the cycle in which tick is high.
REQ-016 Each channel has an FSM with states IDLE, RUN and RELOAD; active is high in RUN and RELOAD.
REQ-017 Load transfer: channel takes state RUN, its counter takes req_count (0 treated as 1), and its periodic flag and reload value are stored; a load to a running channel restarts it without an expire pulse.
REQ-018 Cancel transfer: channel takes state IDLE with no expire pulse; cancelling an IDLE channel has no effect.
REQ-019 In RUN, the counter decrements by 1 on each tick; when the decrement reaches 0, the channel's expire bit is high in the next cycle only.
REQ-020 On expiry, a one-shot channel goes to IDLE; a periodic channel goes to RELOAD for one cycle, reloads the stored value and returns to RUN, so that period = reload value x TICK_DIV cycles exactly with no drift.
REQ-021 Multiple channels expiring on the same tick pulse their expire bits in the same cycle.
REQ-022 The scheduler never accepts a transfer in a tick cycle (REQ-015), so a request and a tick decrement never coincide; a transfer in a RELOAD cycle overrides the reload.
REQ-023 Counter arithmetic is unsigned CNT_W and never underflows below 0.

Reset
REQ-024 While rst is high: prescaler = 0, all channels IDLE, counters = 0, tick = 0, active = 0, expire = 0, req_ready = 0.
REQ-025 Asserting rst mid-count discards all pending expiries; the first tick after rst deasserts occurs TICK_DIV cycles later.

Configuration
REQ-026 Macro TICK_SCHED_PERIODIC_EN defined: periodic mode and the RELOAD state are compiled in as specified.
REQ-027 Macro TICK_SCHED_PERIODIC_EN undefined: req_periodic is ignored, the RELOAD state and reload registers are absent, and every expiry returns the channel to IDLE.

Structure
REQ-028 Shared package tick_sched_pkg holds the channel FSM state enumeration, the channel count constant (4) and the default TICK_DIV.
REQ-029 The prescaler is the sub-module tick_gen (clk_100mhz, rst, tick; parameter TICK_DIV), instantiated once; the channel logic stays in tick_scheduler.

Verification (TICK_DIV=10 for simulation)
REQ-030 rst for 3 cycles, then idle -> tick pulses every 10 cycles, first pulse 10 cycles after rst deasserts; active = 0 and expire = 0 throughout.
REQ-031 Load ch0 count=3 one-shot -> expire[0] pulses once, in the cycle after the third tick following acceptance; active[0] then drops to 0.
REQ-032 Load ch1 count=2 periodic (macro defined) -> expire[1] pulses every 20 cycles, five times with no drift; with the macro undefined, expire[1] pulses once only.
REQ-033 Load ch2 count=5 and cancel it after 2 ticks -> active[2] = 0 and no expire[2] pulse; reload ch2 count=1 before expiry -> expire[2] in the cycle after the next tick.
REQ-034 Hold req_valid across a tick cycle -> req_ready is low in that cycle only and the request transfers in the following cycle; load ch0 and ch3 count=4 on consecutive cycles -> expire[0] and expire[3] pulse in the same cycle.
REQ-035 Assert rst while ch0 is 1 tick from expiry -> no expire pulse and all outputs return to their reset values.
